// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through data cache in front of a tagged memory bus.
// Load misses park in an MSHR table; fills and hits share one registered CDB/PRF port.
module dcache_ctrl #(
  parameter int IDX_BITS = 5,
  parameter int N_MSHR   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Dcache_rd_mem,
  input  logic [63:0] Dcache_addr,
  input  logic [6:0]  Dcache_pr_idx,
  input  logic [4:0]  Dcache_ar_idx,
  output logic        Dcache_avail,
  input  logic        st_retire,
  input  logic [63:0] Dcache_st_addr,
  input  logic [63:0] Dcache_st_value,
  output logic        st_busy,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic        cdb_complete,
  output logic        prf_pr_wr_enable,
  output logic [6:0]  cdb_prf_pr_idx,
  output logic [4:0]  cdb_ar_idx,
  output logic [63:0] prf_pr_value
);
  localparam int LINES = 1 << IDX_BITS;
  localparam int TAG_W = 13 - IDX_BITS;
  localparam int MI_W  = (N_MSHR > 1) ? $clog2(N_MSHR) : 1;

  typedef enum logic [1:0] {FREE, NEED_ISSUE, WAIT_TAG} mshr_st_e;
  typedef struct packed {
    mshr_st_e    st;
    logic [60:0] line;
    logic [6:0]  pr;
    logic [4:0]  ar;
    logic [3:0]  mtag;
    logic        merge;
    logic [63:0] mdata;
  } mshr_t;
  typedef struct packed {
    logic        vld;
    logic [6:0]  pr;
    logic [4:0]  ar;
    logic [63:0] data;
  } cmpl_t;

  logic [LINES-1:0] line_vld;
  logic [TAG_W-1:0] line_tag  [LINES];
  logic [63:0]      line_data [LINES];

  mshr_t mshr [N_MSHR];
  mshr_t mshr_n [N_MSHR];
  // older[i][j]: entry i was allocated before entry j
  logic [N_MSHR-1:0][N_MSHR-1:0] older, older_n;
  logic [N_MSHR-1:0] ni_mask;

  logic        sb_vld;
  logic [60:0] sb_line;
  logic [63:0] sb_data;
  cmpl_t       hold, hold_n, cdb, cdb_n, hit_c;

  logic [IDX_BITS-1:0] ld_idx, st_idx, fill_lidx;
  logic [TAG_W-1:0]    ld_tag, st_tag;
  logic                ld_hit, ld_acc, st_hit, mem_acc, ld_issue_acc;
  logic                free_any, iss_vld, fill_vld, blocked;
  logic [MI_W-1:0]     alloc_idx, iss_idx, fill_idx;
  logic [63:0]         fill_data;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^{Dcache_addr[2:0], Dcache_st_addr[2:0]};

  assign ld_idx  = Dcache_addr[IDX_BITS+2:3];
  assign ld_tag  = Dcache_addr[15:IDX_BITS+3];
  assign st_idx  = Dcache_st_addr[IDX_BITS+2:3];
  assign st_tag  = Dcache_st_addr[15:IDX_BITS+3];
  assign ld_hit  = line_vld[ld_idx] && (line_tag[ld_idx] == ld_tag);
  assign st_hit  = st_retire && line_vld[st_idx] && (line_tag[st_idx] == st_tag);
  assign ld_acc  = Dcache_rd_mem && Dcache_avail;
  assign mem_acc = (mem2proc_response != 4'd0);
  assign ld_issue_acc = !sb_vld && iss_vld && mem_acc;

  assign Dcache_avail     = !hold.vld && free_any;
  assign st_busy          = sb_vld;
  assign cdb_complete     = cdb.vld;
  assign prf_pr_wr_enable = cdb.vld;
  assign cdb_prf_pr_idx   = cdb.pr;
  assign cdb_ar_idx       = cdb.ar;
  assign prf_pr_value     = cdb.data;

  // Output / decode logic: everything here depends on registered state plus fill tag
  always_comb begin
    free_any  = 1'b0;
    alloc_idx = '0;
    iss_vld   = 1'b0;
    iss_idx   = '0;
    fill_vld  = 1'b0;
    fill_idx  = '0;
    blocked   = 1'b0;
    ni_mask   = '0;
    for (int i = 0; i < N_MSHR; i++) ni_mask[i] = (mshr[i].st == NEED_ISSUE);
    for (int i = N_MSHR-1; i >= 0; i--) begin
      if (mshr[i].st == FREE) begin
        free_any  = 1'b1;
        alloc_idx = MI_W'(i);
      end
    end
    for (int i = 0; i < N_MSHR; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < N_MSHR; j++) if (ni_mask[j] && older[j][i]) blocked = 1'b1;
      if (ni_mask[i] && !blocked && !iss_vld) begin
        iss_vld = 1'b1;
        iss_idx = MI_W'(i);
      end
      if (mshr[i].st == WAIT_TAG && mem2proc_tag != 4'd0 && mshr[i].mtag == mem2proc_tag) begin
        fill_vld = 1'b1;
        fill_idx = MI_W'(i);
      end
    end
    proc2mem_command = 2'd0;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (sb_vld) begin
      proc2mem_command = 2'd2;
      proc2mem_addr    = {sb_line, 3'b000};
      proc2mem_data    = sb_data;
    end else if (iss_vld) begin
      proc2mem_command = 2'd1;
      proc2mem_addr    = {mshr[iss_idx].line, 3'b000};
    end
  end

  // Next-state logic for MSHRs, age matrix, hold register and CDB
  always_comb begin
    for (int i = 0; i < N_MSHR; i++) mshr_n[i] = mshr[i];
    older_n   = older;
    fill_lidx = mshr[fill_idx].line[IDX_BITS-1:0];
    fill_data = mshr[fill_idx].merge ? mshr[fill_idx].mdata : mem2proc_data;
    // a store to the filling line in the same cycle is the newest value
    if (st_retire && mshr[fill_idx].line[12:0] == Dcache_st_addr[15:3]) fill_data = Dcache_st_value;
    for (int i = 0; i < N_MSHR; i++) begin
      if (st_retire && mshr[i].st != FREE && mshr[i].line[12:0] == Dcache_st_addr[15:3]) begin
        mshr_n[i].merge = 1'b1;
        mshr_n[i].mdata = Dcache_st_value;
      end
    end
    if (ld_issue_acc) begin
      mshr_n[iss_idx].st   = WAIT_TAG;
      mshr_n[iss_idx].mtag = mem2proc_response;
    end
    if (fill_vld) mshr_n[fill_idx].st = FREE;
    if (ld_acc && !ld_hit) begin
      mshr_n[alloc_idx].st    = NEED_ISSUE;
      mshr_n[alloc_idx].line  = Dcache_addr[63:3];
      mshr_n[alloc_idx].pr    = Dcache_pr_idx;
      mshr_n[alloc_idx].ar    = Dcache_ar_idx;
      mshr_n[alloc_idx].mtag  = 4'd0;
      mshr_n[alloc_idx].merge = st_retire && (Dcache_st_addr[15:3] == Dcache_addr[15:3]);
      mshr_n[alloc_idx].mdata = Dcache_st_value;
      for (int j = 0; j < N_MSHR; j++) begin
        older_n[alloc_idx][j] = 1'b0;
        older_n[j][alloc_idx] = (j != int'(alloc_idx));
      end
    end
    hit_c  = '{vld: 1'b1, pr: Dcache_pr_idx, ar: Dcache_ar_idx, data: line_data[ld_idx]};
    cdb_n  = '0;
    hold_n = hold;
    if (fill_vld) begin
      cdb_n = '{vld: 1'b1, pr: mshr[fill_idx].pr, ar: mshr[fill_idx].ar, data: fill_data};
      if (ld_acc && ld_hit) hold_n = hit_c;
    end else if (hold.vld) begin
      cdb_n  = hold;
      hold_n = '0;
    end else if (ld_acc && ld_hit) begin
      cdb_n = hit_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_MSHR; i++) mshr[i] <= '0;
      older   <= '0;
      sb_vld  <= 1'b0;
      sb_line <= '0;
      sb_data <= '0;
      hold    <= '0;
      cdb     <= '0;
    end else begin
      for (int i = 0; i < N_MSHR; i++) mshr[i] <= mshr_n[i];
      older <= older_n;
      hold  <= hold_n;
      cdb   <= cdb_n;
      if (st_retire) begin
        sb_vld  <= 1'b1;
        sb_line <= Dcache_st_addr[63:3];
        sb_data <= Dcache_st_value;
      end else if (sb_vld && mem_acc) begin
        sb_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) line_vld <= '0;
    else if (fill_vld) line_vld[fill_lidx] <= 1'b1;
  end

  // fill is written after the store hit so it wins on the same index
  always_ff @(posedge clock) begin
    if (st_hit) line_data[st_idx] <= Dcache_st_value;
    if (fill_vld) begin
      line_data[fill_lidx] <= fill_data;
      line_tag[fill_lidx]  <= mshr[fill_idx].line[12:IDX_BITS];
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scenario bench for dcache_ctrl: expected CDB completions are queued as
// stimulus is driven and popped by a monitor when the DUT pulses cdb_complete.
module tb_dcache_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        Dcache_rd_mem, st_retire;
  logic [63:0] Dcache_addr, Dcache_st_addr, Dcache_st_value, mem2proc_data;
  logic [6:0]  Dcache_pr_idx;
  logic [4:0]  Dcache_ar_idx;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic        Dcache_avail, st_busy, cdb_complete, prf_pr_wr_enable;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr, proc2mem_data, prf_pr_value;
  logic [6:0]  cdb_prf_pr_idx;
  logic [4:0]  cdb_ar_idx;

  always #5 clock = ~clock;

  dcache_ctrl #(.IDX_BITS(5), .N_MSHR(4)) dut (
    .clock(clock), .reset(reset),
    .Dcache_rd_mem(Dcache_rd_mem), .Dcache_addr(Dcache_addr),
    .Dcache_pr_idx(Dcache_pr_idx), .Dcache_ar_idx(Dcache_ar_idx),
    .Dcache_avail(Dcache_avail),
    .st_retire(st_retire), .Dcache_st_addr(Dcache_st_addr),
    .Dcache_st_value(Dcache_st_value), .st_busy(st_busy),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .cdb_complete(cdb_complete), .prf_pr_wr_enable(prf_pr_wr_enable),
    .cdb_prf_pr_idx(cdb_prf_pr_idx), .cdb_ar_idx(cdb_ar_idx),
    .prf_pr_value(prf_pr_value)
  );

  int checks = 0;
  int errors = 0;
  logic [75:0] exp_q[$];

  // scoreboard monitor: {pr, ar, value}
  always @(negedge clock) begin
    if (!reset && cdb_complete) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cdb_unexpected: got pr=%0d ar=%0d val=%h, none expected",
                 cdb_prf_pr_idx, cdb_ar_idx, prf_pr_value);
      end else begin
        logic [75:0] e;
        e = exp_q.pop_front();
        if ({cdb_prf_pr_idx, cdb_ar_idx, prf_pr_value} !== e || prf_pr_wr_enable !== 1'b1) begin
          errors++;
          $display("FAIL cdb_value: got pr=%0d ar=%0d val=%h we=%b, exp pr=%0d ar=%0d val=%h",
                   cdb_prf_pr_idx, cdb_ar_idx, prf_pr_value, prf_pr_wr_enable,
                   e[75:69], e[68:64], e[63:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic idle_inputs();
    Dcache_rd_mem = 0; Dcache_addr = '0; Dcache_pr_idx = '0; Dcache_ar_idx = '0;
    st_retire = 0; Dcache_st_addr = '0; Dcache_st_value = '0;
    mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
  endtask

  task automatic drive_load(input logic [63:0] a, input logic [6:0] pr, input logic [4:0] ar);
    Dcache_rd_mem = 1; Dcache_addr = a; Dcache_pr_idx = pr; Dcache_ar_idx = ar;
    step();
    Dcache_rd_mem = 0;
  endtask

  task automatic drive_fill(input logic [3:0] t, input logic [63:0] d);
    mem2proc_tag = t; mem2proc_data = d;
    step();
    mem2proc_tag = '0; mem2proc_data = '0;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d completions outstanding, exp 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs();
    step(); step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cdb_complete !== 1'b0) begin errors++; $display("FAIL rst_cdb: got %b exp 0", cdb_complete); end
    checks++; if (prf_pr_value !== 64'd0) begin errors++; $display("FAIL rst_value: got %h exp 0", prf_pr_value); end
    checks++; if (proc2mem_command !== 2'd0) begin errors++; $display("FAIL rst_cmd: got %0d exp 0", proc2mem_command); end
    checks++; if (st_busy !== 1'b0) begin errors++; $display("FAIL rst_st_busy: got %b exp 0", st_busy); end
    checks++; if (Dcache_avail !== 1'b1) begin errors++; $display("FAIL rst_avail: got %b exp 1", Dcache_avail); end
  endtask

  task automatic test_miss_then_hit();
    drive_load(64'h100, 7'd10, 5'd3);
    checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 64'h100) begin
      errors++; $display("FAIL miss_issue: got cmd=%0d addr=%h exp cmd=1 addr=100", proc2mem_command, proc2mem_addr); end
    mem2proc_response = 4'd3;
    step();
    mem2proc_response = 4'd0;
    checks++; if (proc2mem_command !== 2'd0) begin errors++; $display("FAIL miss_wait_cmd: got %0d exp 0", proc2mem_command); end
    exp_q.push_back({7'd10, 5'd3, 64'hAB});
    drive_fill(4'd3, 64'hAB);
    drain();
    exp_q.push_back({7'd11, 5'd4, 64'hAB});
    drive_load(64'h100, 7'd11, 5'd4);
    checks++; if (cdb_complete !== 1'b1) begin errors++; $display("FAIL hit_latency: got cdb=%b exp 1 at n+1", cdb_complete); end
    checks++; if (proc2mem_command !== 2'd0) begin errors++; $display("FAIL hit_no_bus: got cmd=%0d exp 0", proc2mem_command); end
    drain();
  endtask

  task automatic test_four_misses();
    logic [3:0] order [4];
    order[0] = 4'd2; order[1] = 4'd1; order[2] = 4'd4; order[3] = 4'd3;
    for (int k = 0; k < 4; k++) begin
      checks++; if (Dcache_avail !== 1'b1) begin errors++; $display("FAIL four_avail_pre%0d: got %b exp 1", k, Dcache_avail); end
      drive_load(64'(k * 8), 7'(20 + k), 5'(1 + k));
    end
    checks++; if (Dcache_avail !== 1'b0) begin errors++; $display("FAIL four_avail_full: got %b exp 0", Dcache_avail); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 64'(k * 8)) begin
        errors++; $display("FAIL four_issue%0d: got cmd=%0d addr=%h exp cmd=1 addr=%h", k, proc2mem_command, proc2mem_addr, k * 8); end
      mem2proc_response = 4'(k + 1);
      step();
    end
    mem2proc_response = 4'd0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({7'(20 + order[k] - 1), 5'(order[k]), 64'h1000 + 64'(order[k])});
      drive_fill(order[k], 64'h1000 + 64'(order[k]));
    end
    drain();
    checks++; if (Dcache_avail !== 1'b1) begin errors++; $display("FAIL four_avail_post: got %b exp 1", Dcache_avail); end
  endtask

  task automatic test_retry();
    drive_load(64'h300, 7'd30, 5'd2);
    for (int c = 0; c < 3; c++) begin
      checks++; if (proc2mem_command !== 2'd1 || proc2mem_addr !== 64'h300) begin
        errors++; $display("FAIL retry_hold%0d: got cmd=%0d addr=%h exp cmd=1 addr=300", c, proc2mem_command, proc2mem_addr); end
      mem2proc_response = (c == 2) ? 4'd5 : 4'd0;
      step();
    end
    mem2proc_response = 4'd0;
    checks++; if (proc2mem_command !== 2'd0) begin errors++; $display("FAIL retry_waiting: got cmd=%0d exp 0", proc2mem_command); end
    drive_fill(4'd4, 64'hDEAD);
    exp_q.push_back({7'd30, 5'd2, 64'h77});
    drive_fill(4'd5, 64'h77);
    drain();
  endtask

  task automatic test_fill_hit_collide();
    drive_load(64'h400, 7'd40, 5'd6);
    mem2proc_response = 4'd6;
    step();
    mem2proc_response = 4'd0;
    exp_q.push_back({7'd40, 5'd6, 64'h99});
    exp_q.push_back({7'd41, 5'd7, 64'h1002});
    Dcache_rd_mem = 1; Dcache_addr = 64'h8; Dcache_pr_idx = 7'd41; Dcache_ar_idx = 5'd7;
    mem2proc_tag = 4'd6; mem2proc_data = 64'h99;
    step();
    Dcache_rd_mem = 0; mem2proc_tag = 4'd0; mem2proc_data = '0;
    checks++; if (Dcache_avail !== 1'b0) begin errors++; $display("FAIL collide_avail: got %b exp 0", Dcache_avail); end
    checks++; if (cdb_prf_pr_idx !== 7'd40) begin errors++; $display("FAIL collide_fill_first: got pr=%0d exp 40", cdb_prf_pr_idx); end
    step();
    checks++; if (cdb_complete !== 1'b1 || cdb_prf_pr_idx !== 7'd41) begin
      errors++; $display("FAIL collide_hit_n2: got cdb=%b pr=%0d exp cdb=1 pr=41", cdb_complete, cdb_prf_pr_idx); end
    checks++; if (Dcache_avail !== 1'b1) begin errors++; $display("FAIL collide_avail_back: got %b exp 1", Dcache_avail); end
    drain();
  endtask

  task automatic test_store_merge();
    drive_load(64'h200, 7'd50, 5'd9);
    checks++; if (proc2mem_command !== 2'd1) begin errors++; $display("FAIL merge_pending_load: got cmd=%0d exp 1", proc2mem_command); end
    st_retire = 1; Dcache_st_addr = 64'h200; Dcache_st_value = 64'h55;
    step();
    st_retire = 0;
    checks++; if (st_busy !== 1'b1) begin errors++; $display("FAIL merge_st_busy: got %b exp 1", st_busy); end
    checks++; if (proc2mem_command !== 2'd2 || proc2mem_addr !== 64'h200 || proc2mem_data !== 64'h55) begin
      errors++; $display("FAIL merge_store_first: got cmd=%0d addr=%h data=%h exp cmd=2 addr=200 data=55",
                         proc2mem_command, proc2mem_addr, proc2mem_data); end
    mem2proc_response = 4'd7;
    step();
    checks++; if (st_busy !== 1'b0 || proc2mem_command !== 2'd1 || proc2mem_addr !== 64'h200) begin
      errors++; $display("FAIL merge_load_after: got busy=%b cmd=%0d addr=%h exp busy=0 cmd=1 addr=200",
                         st_busy, proc2mem_command, proc2mem_addr); end
    mem2proc_response = 4'd8;
    step();
    mem2proc_response = 4'd0;
    exp_q.push_back({7'd50, 5'd9, 64'h55});
    drive_fill(4'd8, 64'h11);
    drain();
    exp_q.push_back({7'd51, 5'd9, 64'h55});
    drive_load(64'h200, 7'd51, 5'd9);
    checks++; if (cdb_complete !== 1'b1 || prf_pr_value !== 64'h55) begin
      errors++; $display("FAIL merge_rehit: got cdb=%b val=%h exp cdb=1 val=55", cdb_complete, prf_pr_value); end
    drain();
  endtask

  task automatic test_reset_mid_miss();
    drive_load(64'h500, 7'd60, 5'd1);
    drive_load(64'h608, 7'd61, 5'd2);
    mem2proc_response = 4'd9;
    step();
    mem2proc_response = 4'd10;
    step();
    mem2proc_response = 4'd0;
    do_reset();
    checks++; if (proc2mem_command !== 2'd0) begin errors++; $display("FAIL midrst_cmd: got %0d exp 0", proc2mem_command); end
    drive_fill(4'd9, 64'h1234);
    drive_fill(4'd10, 64'h5678);
    step();
    checks++; if (cdb_complete !== 1'b0) begin errors++; $display("FAIL midrst_cdb: got %b exp 0", cdb_complete); end
    checks++; if (Dcache_avail !== 1'b1) begin errors++; $display("FAIL midrst_avail: got %b exp 1", Dcache_avail); end
    drain();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_miss_then_hit();
    test_four_misses();
    test_retry();
    test_fill_hit_collide();
    test_store_merge();
    test_reset_mid_miss();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
